// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: matrix keypad scanner with per-key debounce and an
// event FIFO (first-word-fall-through, valid/ready).
// One column is driven low at a time for SCAN_DIV clocks. The rows are
// sampled through a two-flop synchroniser on the last clock of that window.
// Every key has its own debounce counter. Key changes from one column sample
// are pushed into the FIFO one per clock, lowest row first.
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat press
// events every REPEAT_FRAMES frames while a key is held.
module keypad_scan_debounce #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int DEBOUNCE      = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_FRAMES = 30
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ROWS-1:0]                row_in,
    output logic [COLS-1:0]                col_out,
    output logic [ROWS*COLS-1:0]           keys,
    output logic                           scan,
    output logic                           evt_valid,
    output logic [$clog2(ROWS*COLS)-1:0]   evt_code,
    output logic                           evt_press,
    input  logic                           evt_ready,
    output logic                           overflow
);

    localparam int NKEYS = ROWS * COLS;
    localparam int CW    = $clog2(NKEYS);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [3:0]       DB_LIMIT = 4'(DEBOUNCE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Column scanner
    // ------------------------------------------------------------------
    logic             active_reg;
    logic [DIV_W-1:0] div_reg;
    logic [COL_W-1:0] col_reg;
    logic             scan_reg;
    logic [ROWS-1:0]  sync1_reg;
    logic [ROWS-1:0]  sync2_reg;
    logic             sample_en;

    assign sample_en = active_reg && (div_reg == DIV_LAST);

    // Divider and column pointer; the frame pulse fires on the wrap to column 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            active_reg <= 1'b0;
            div_reg    <= '0;
            col_reg    <= '0;
            scan_reg   <= 1'b0;
        end else begin
            scan_reg <= 1'b0;
            if (!active_reg) begin
                active_reg <= 1'b1;
            end else if (sample_en) begin
                div_reg <= '0;
                if (col_reg == COL_LAST) begin
                    col_reg  <= '0;
                    scan_reg <= 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end else begin
                div_reg <= div_reg + 1'b1;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous row pins (idle = pulled up).
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= row_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Drive the selected column low; all high until scanning starts.
    always_comb begin
        col_out = '1;
        if (active_reg) begin
            col_out[col_reg] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Per-key debounce (and optional repeat)
    // ------------------------------------------------------------------
    logic [NKEYS-1:0] keys_reg;
    logic [NKEYS-1:0] evt_flag;

    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_key
            localparam int R = gi / COLS;
            localparam int C = gi % COLS;
            logic [3:0] cnt_reg;
            logic       key_reg;
            logic       hit;
            logic       raw;
            logic       flip;

            assign hit  = sample_en && (col_reg == COL_W'(C));
            assign raw  = ~sync2_reg[R];
            assign flip = hit && (raw != key_reg) && (cnt_reg + 4'd1 == DB_LIMIT);
            assign keys_reg[gi] = key_reg;

            // Count consecutive disagreeing samples; flip the key when they reach the limit.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_reg <= '0;
                    key_reg <= 1'b0;
                end else if (hit) begin
                    if (raw == key_reg) begin
                        cnt_reg <= '0;
                    end else if (flip) begin
                        cnt_reg <= '0;
                        key_reg <= ~key_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
            end

`ifdef KEYPAD_REPEAT_EN
            localparam int RW = $clog2(REPEAT_FRAMES + 1);
            localparam logic [RW-1:0] REP_LIMIT = RW'(REPEAT_FRAMES);
            logic [RW-1:0] rep_cnt_reg;
            logic          rep;

            assign rep = hit && raw && key_reg && (rep_cnt_reg + RW'(1) == REP_LIMIT);
            assign evt_flag[gi] = flip | rep;

            // Frames held since the last press event; restarts on press, repeat and release.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rep_cnt_reg <= '0;
                end else if (flip || rep) begin
                    rep_cnt_reg <= '0;
                end else if (hit && raw && key_reg) begin
                    rep_cnt_reg <= rep_cnt_reg + RW'(1);
                end
            end
`else
            assign evt_flag[gi] = flip;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Event serialiser: one push per clock, ascending row order
    // ------------------------------------------------------------------
    logic [ROWS-1:0]  row_flag;
    logic [ROWS-1:0]  pend_reg;
    logic [ROWS-1:0]  pend_press_reg;
    logic [COL_W-1:0] pend_col_reg;
    logic             pick_valid;
    logic [ROW_W-1:0] pick_row;
    logic             push;
    logic [CW-1:0]    push_code;
    logic             push_press;

    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            logic [COLS-1:0] row_slice;
            assign row_slice    = evt_flag[gi*COLS +: COLS];
            assign row_flag[gi] = row_slice[col_reg];
        end
    endgenerate

    // Lowest pending row wins (descending loop lets lower rows overwrite).
    always_comb begin
        pick_valid = 1'b0;
        pick_row   = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (pend_reg[r]) begin
                pick_valid = 1'b1;
                pick_row   = ROW_W'(r);
            end
        end
    end

    assign push       = pick_valid;
    assign push_code  = CW'(int'(pick_row) * COLS + int'(pend_col_reg));
    assign push_press = pend_press_reg[pick_row];

    // Capture the changed rows of a column sample, then retire one per clock.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_reg       <= '0;
            pend_press_reg <= '0;
            pend_col_reg   <= '0;
        end else if (sample_en) begin
            pend_reg       <= row_flag;
            pend_press_reg <= ~sync2_reg;
            pend_col_reg   <= col_reg;
        end else if (pick_valid) begin
            pend_reg[pick_row] <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [CW:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          overflow_reg;
    logic          full;
    logic          pop;
    logic          wr_en;

    assign full  = (count_reg == FULL_CNT);
    assign pop   = (count_reg != '0) && evt_ready;
    assign wr_en = push && (!full || pop);

    // Storage write; the slot freed by a same-clock pop is reusable when full.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {push_press, push_code};
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push && full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign evt_valid             = (count_reg != '0);
    assign {evt_press, evt_code} = mem[rd_ptr_reg];
    assign keys                  = keys_reg;
    assign scan                  = scan_reg;
    assign overflow              = overflow_reg;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed testbench for keypad_scan_debounce (4x4, SCAN_DIV=8, DEBOUNCE=2,
// FIFO_DEPTH=4, REPEAT_FRAMES=3). A behavioural keypad pulls a row low when
// a held key sits in the currently driven column. Accepted events are logged
// with their cycle number.
module tb_keypad_scan_debounce;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [ROWS-1:0]         row_in;
    logic [COLS-1:0]         col_out;
    logic [ROWS*COLS-1:0]    keys;
    logic                    scan;
    logic                    evt_valid;
    logic [3:0]              evt_code;
    logic                    evt_press;
    logic                    evt_ready = 1'b1;
    logic                    overflow;

    logic [ROWS*COLS-1:0]    key_down = '0;

    typedef struct {
        int code;
        bit press;
        int cyc;
    } evt_t;

    evt_t log_q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    keypad_scan_debounce #(
        .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE(2),
        .FIFO_DEPTH(4), .REPEAT_FRAMES(3)
    ) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .keys(keys), .scan(scan), .evt_valid(evt_valid), .evt_code(evt_code),
        .evt_press(evt_press), .evt_ready(evt_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad model: a pressed key shorts its row to the driven (low) column.
    always_comb begin
        row_in = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (key_down[r*COLS+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    // Record every accepted event.
    always @(negedge clk) begin
        evt_t e;
        if (rst && evt_valid && evt_ready) begin
            e.code  = int'(evt_code);
            e.press = evt_press;
            e.cyc   = cyc;
            log_q.push_back(e);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Align to one clock after the start of a frame (bounded wait on scan).
    task automatic wait_scan();
        int budget = 0;
        @(negedge clk);
        while (scan !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        tests++;
        if (scan !== 1'b1) begin
            fails++;
            $display("FAIL wait_scan: no scan pulse within %0d clocks", budget);
        end
        step(1);
    endtask

    task automatic test_reset();
        logic [3:0] exp_col [3];
        int scan_cnt = 0;
        int first = -1;
        int last = -1;
        exp_col[0] = 4'b1101;
        exp_col[1] = 4'b1011;
        exp_col[2] = 4'b0111;
        rst = 1'b0;
        key_down = '0;
        evt_ready = 1'b1;
        step(3);
        tests++; if (col_out !== 4'b1111) begin fails++; $display("FAIL reset_col: got %b want 1111", col_out); end
        tests++; if (keys !== 16'h0) begin fails++; $display("FAIL reset_keys: got %h want 0000", keys); end
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        tests++; if (scan !== 1'b0) begin fails++; $display("FAIL reset_scan: got %b want 0", scan); end
        rst = 1'b1;
        step(1);
        tests++; if (col_out !== 4'b1110) begin fails++; $display("FAIL first_col: got %b want 1110", col_out); end
        for (int k = 0; k < 3; k++) begin
            step(8);
            tests++;
            if (col_out !== exp_col[k]) begin
                fails++;
                $display("FAIL col_step%0d: got %b want %b", k + 1, col_out, exp_col[k]);
            end
        end
        for (int i = 1; i <= 64; i++) begin
            step(1);
            if (scan === 1'b1) begin
                scan_cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
        tests++; if (scan_cnt !== 2) begin fails++; $display("FAIL scan_count: got %0d want 2", scan_cnt); end
        tests++; if (first !== 8) begin fails++; $display("FAIL scan_first: got %0d want 8", first); end
        tests++; if (last - first !== 32) begin fails++; $display("FAIL scan_period: got %0d want 32", last - first); end
        $display("[TB] reset/scan: scan pulses=%0d first=%0d last=%0d", scan_cnt, first, last);
    endtask

    task automatic test_single_key();
        log_q.delete();
        wait_scan();
        key_down[6] = 1'b1;
        step(32);
        tests++; if (keys !== 16'h0000) begin fails++; $display("FAIL key6_early: got %h want 0000", keys); end
        step(32);
        tests++; if (keys !== 16'h0040) begin fails++; $display("FAIL key6_press: got %h want 0040", keys); end
        tests++; if (log_q.size() !== 1) begin fails++; $display("FAIL key6_press_cnt: got %0d want 1", log_q.size()); end
        if (log_q.size() >= 1) begin
            tests++;
            if (log_q[0].code !== 6 || log_q[0].press !== 1'b1) begin
                fails++;
                $display("FAIL key6_press_evt: got code=%0d press=%0d want code=6 press=1", log_q[0].code, log_q[0].press);
            end
        end
        key_down[6] = 1'b0;
        step(64);
        tests++; if (keys !== 16'h0000) begin fails++; $display("FAIL key6_release: got %h want 0000", keys); end
        tests++; if (log_q.size() !== 2) begin fails++; $display("FAIL key6_evt_cnt: got %0d want 2", log_q.size()); end
        if (log_q.size() >= 2) begin
            tests++;
            if (log_q[1].code !== 6 || log_q[1].press !== 1'b0) begin
                fails++;
                $display("FAIL key6_release_evt: got code=%0d press=%0d want code=6 press=0", log_q[1].code, log_q[1].press);
            end
        end
        $display("[TB] single key (1,2): events=%0d keys=%h", log_q.size(), keys);
    endtask

    task automatic test_glitch();
        log_q.delete();
        wait_scan();
        key_down[0] = 1'b1;
        step(32);
        key_down[0] = 1'b0;
        step(64);
        tests++; if (keys !== 16'h0000) begin fails++; $display("FAIL glitch_keys: got %h want 0000", keys); end
        tests++; if (log_q.size() !== 0) begin fails++; $display("FAIL glitch_evts: got %0d want 0", log_q.size()); end
        $display("[TB] glitch (0,0) one frame: events=%0d keys=%h", log_q.size(), keys);
    endtask

    task automatic test_back_to_back();
        log_q.delete();
        wait_scan();
        key_down[1]  = 1'b1;
        key_down[13] = 1'b1;
        step(64);
        tests++; if (keys !== 16'h2002) begin fails++; $display("FAIL b2b_keys: got %h want 2002", keys); end
        tests++; if (log_q.size() !== 2) begin fails++; $display("FAIL b2b_cnt: got %0d want 2", log_q.size()); end
        if (log_q.size() >= 2) begin
            tests++;
            if (log_q[0].code !== 1 || log_q[1].code !== 13 || log_q[0].press !== 1'b1 || log_q[1].press !== 1'b1) begin
                fails++;
                $display("FAIL b2b_order: got %0d/%0d,%0d/%0d want 1/1,13/1",
                         log_q[0].code, log_q[0].press, log_q[1].code, log_q[1].press);
            end
            tests++;
            if (log_q[1].cyc - log_q[0].cyc !== 1) begin
                fails++;
                $display("FAIL b2b_gap: got %0d want 1", log_q[1].cyc - log_q[0].cyc);
            end
        end
        key_down[1]  = 1'b0;
        key_down[13] = 1'b0;
        step(64);
        tests++; if (log_q.size() !== 4) begin fails++; $display("FAIL b2b_rel_cnt: got %0d want 4", log_q.size()); end
        if (log_q.size() >= 4) begin
            tests++;
            if (log_q[2].code !== 1 || log_q[3].code !== 13 || log_q[2].press !== 1'b0 || log_q[3].press !== 1'b0) begin
                fails++;
                $display("FAIL b2b_release: got %0d/%0d,%0d/%0d want 1/0,13/0",
                         log_q[2].code, log_q[2].press, log_q[3].code, log_q[3].press);
            end
        end
        $display("[TB] two keys (0,1)+(3,1): events=%0d keys=%h", log_q.size(), keys);
    endtask

    task automatic test_overflow();
        int exp_code [4];
        exp_code[0] = 0;
        exp_code[1] = 4;
        exp_code[2] = 8;
        exp_code[3] = 12;
        log_q.delete();
        evt_ready = 1'b0;
        wait_scan();
        key_down = 16'h1113;
        step(64);
        tests++; if (keys !== 16'h1113) begin fails++; $display("FAIL ovf_keys: got %h want 1113", keys); end
        tests++; if (evt_valid !== 1'b1 || evt_code !== 4'd0 || evt_press !== 1'b1) begin
            fails++; $display("FAIL ovf_head: got v=%b code=%0d p=%b want v=1 code=0 p=1", evt_valid, evt_code, evt_press); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        evt_ready = 1'b1;
        step(6);
        tests++; if (log_q.size() !== 4) begin fails++; $display("FAIL ovf_drain_cnt: got %0d want 4", log_q.size()); end
        if (log_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (log_q[i].code !== exp_code[i] || log_q[i].press !== 1'b1) begin
                    fails++;
                    $display("FAIL ovf_drain%0d: got code=%0d p=%0d want code=%0d p=1", i, log_q[i].code, log_q[i].press, exp_code[i]);
                end
            end
            tests++;
            if (log_q[3].cyc - log_q[0].cyc !== 3) begin
                fails++; $display("FAIL ovf_drain_rate: got %0d want 3", log_q[3].cyc - log_q[0].cyc);
            end
        end
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty: got %b want 0", evt_valid); end
        step(40);
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        rst = 1'b0;
        step(2);
        tests++; if (keys !== 16'h0 || overflow !== 1'b0 || evt_valid !== 1'b0 || col_out !== 4'hf) begin
            fails++; $display("FAIL midscan_reset: keys=%h ovf=%b v=%b col=%b want 0000 0 0 1111", keys, overflow, evt_valid, col_out); end
        key_down = '0;
        rst = 1'b1;
        step(1);
        $display("[TB] overflow: drained=%0d overflow after reset=%b", log_q.size(), overflow);
    endtask

    task automatic test_hold();
        int presses = 0;
        int releases = 0;
        int others = 0;
        int exp_presses;
`ifdef KEYPAD_REPEAT_EN
        exp_presses = 4;
`else
        exp_presses = 1;
`endif
        log_q.delete();
        evt_ready = 1'b1;
        wait_scan();
        key_down[5] = 1'b1;
        step(352);
        key_down[5] = 1'b0;
        step(96);
        foreach (log_q[i]) begin
            if (log_q[i].code != 5) others++;
            else if (log_q[i].press) presses++;
            else releases++;
        end
        tests++; if (presses !== exp_presses) begin fails++; $display("FAIL hold_presses: got %0d want %0d", presses, exp_presses); end
        tests++; if (releases !== 1 || others !== 0) begin fails++; $display("FAIL hold_release: got rel=%0d other=%0d want 1 0", releases, others); end
        tests++; if (keys !== 16'h0) begin fails++; $display("FAIL hold_keys: got %h want 0000", keys); end
        $display("[TB] hold key 5: presses=%0d releases=%0d", presses, releases);
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_glitch();
        test_back_to_back();
        test_overflow();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
